servo_pwm_gen: RTL and testbench



---
 rtl/servo_pwm_gen.sv | 147 ++++++++++++++
 tb/tb_servo_pwm_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: 50 Hz hobby-servo pulse generator timed by the divider's
// 100 kHz square wave. The pulse width is MIN_TICKS + position, and a new
// position is taken over a valid/ready handshake. The width is applied only
// at frame starts.
// Optional feature macro: SERVO_SOFT_RAMP_EN. When defined, the applied width
// slews toward its target by at most RAMP_STEP ticks per frame.
// Handshake: a position transfers on any clk where pos_valid && pos_ready.
// pos_ready is 1 in every cycle after reset. The last accepted value wins.
`timescale 1ns/1ps
module servo_pwm_gen #(
  parameter int FRAME_TICKS = 2000,
  parameter int MIN_TICKS   = 100,
  parameter int SPAN        = 100,
  parameter int POS_W       = 8,
  parameter int CNT_W       = 11,
  parameter int RAMP_STEP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [POS_W-1:0] pos_data,
  input  logic             pos_valid,
  output logic             pos_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [CNT_W-1:0] cur_width,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] RESET_W  = CNT_W'(MIN_TICKS + SPAN / 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [POS_W-1:0] SPAN_P   = POS_W'(SPAN);
  localparam logic [POS_W-1:0] NEUTRAL  = POS_W'(SPAN / 2);

  state_t             state, next_state;
  logic [2:0]         tick_sr;
  logic               tick;
  logic [CNT_W-1:0]   counter;
  logic [POS_W-1:0]   pending;
  logic [POS_W-1:0]   pos_clamped;
  logic [POS_W-1:0]   load_pos;
  logic [CNT_W-1:0]   target_w;
  logic [CNT_W-1:0]   next_width;
  logic               accept;
  logic               start_frame;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               frame_end;

  // Two synchronizer flops plus a history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_sr <= '0;
    else     tick_sr <= {tick_sr[1:0], tick_in};
  end

  assign tick = tick_sr[1] & ~tick_sr[2];

  // pos_ready rises on the first clk after reset and then stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_ready <= 1'b0;
    else     pos_ready <= 1'b1;
  end

  assign accept      = pos_valid & pos_ready;
  assign pos_clamped = (pos_data > SPAN_P) ? SPAN_P : pos_data;
  // A position accepted on the load clk takes effect in that same frame.
  assign load_pos    = accept ? pos_clamped : pending;
  assign target_w    = MIN_W + CNT_W'(load_pos);

  // Pending position register: the last accepted value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pending <= NEUTRAL;
    else if (accept) pending <= pos_clamped;
  end

`ifdef SERVO_SOFT_RAMP_EN
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(RAMP_STEP);
  // Slew toward the target, landing exactly on it when within one step.
  always_comb begin
    next_width = target_w;
    if (target_w > cur_width + STEP_W)      next_width = cur_width + STEP_W;
    else if (cur_width > target_w + STEP_W) next_width = cur_width - STEP_W;
  end
`else
  assign next_width = target_w;
`endif

  assign frame_end = (state == LOW) && (counter == LAST_CNT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: every transition happens on a tick.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (tick && enable) next_state = HIGH;
      HIGH: if (tick && ((counter + ONE) == cur_width)) next_state = LOW;
      LOW:  if (tick && frame_end) next_state = enable ? HIGH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath controls decoded from the state and the tick.
  always_comb begin
    start_frame = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    if (tick) begin
      start_frame = enable && ((state == IDLE) || frame_end);
      cnt_clr     = frame_end;
      cnt_inc     = (state == HIGH) || (state == LOW);
    end
  end

  // Counter, applied width and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter     <= '0;
      cur_width   <= RESET_W;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= start_frame;
      pwm_out     <= (next_state == HIGH);
      if (start_frame) begin
        counter   <= '0;
        cur_width <= next_width;
      end else if (cnt_clr) begin
        counter <= '0;
      end else if (cnt_inc) begin
        counter <= counter + ONE;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: checks servo_pwm_gen against a frame-level model.
// The model predicts one applied width per frame, and a monitor checks each
// observed frame start, pulse length and frame period against it.
`timescale 1ns/1ps
module tb_servo_pwm_gen;

  localparam int FRAME_TICKS = 2000;
  localparam int MIN_TICKS   = 100;
  localparam int SPAN        = 100;
  localparam int POS_W       = 8;
  localparam int CNT_W       = 11;
  localparam int RAMP_STEP   = 4;
  localparam int TICK_CLKS   = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick_in;
  logic             enable;
  logic [POS_W-1:0] pos_data;
  logic             pos_valid;
  logic             pos_ready;
  logic             pwm_out;
  logic             frame_start;
  logic [CNT_W-1:0] cur_width;
  logic [1:0]       state_dbg;

  // Scoreboard entries: {back_to_back_frame, expected_width}
  logic [CNT_W:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level reference model state
  int m_pending;
  bit m_active;
  int m_pos;
  int m_width;
  int m_frames;
  int frames_seen = 0;

  servo_pwm_gen #(
    .FRAME_TICKS(FRAME_TICKS), .MIN_TICKS(MIN_TICKS), .SPAN(SPAN),
    .POS_W(POS_W), .CNT_W(CNT_W), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable),
    .pos_data(pos_data), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pwm_out(pwm_out), .frame_start(frame_start), .cur_width(cur_width),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (got %0d/%0d checks passed so far)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Reference model
  task automatic model_reset();
    m_pending = SPAN / 2;
    m_active  = 1'b0;
    m_pos     = 0;
    m_width   = MIN_TICKS + SPAN / 2;
  endtask

  task automatic model_start(input bit consec);
    int target;
    target = MIN_TICKS + m_pending;
`ifdef SERVO_SOFT_RAMP_EN
    if (target > m_width + RAMP_STEP)      m_width = m_width + RAMP_STEP;
    else if (m_width > target + RAMP_STEP) m_width = m_width - RAMP_STEP;
    else                                   m_width = target;
`else
    m_width = target;
`endif
    m_active = 1'b1;
    m_pos    = 0;
    m_frames++;
    exp_q.push_back({consec, CNT_W'(m_width)});
  endtask

  // One timebase tick as the model sees it, including an optional write
  // that lands on that tick's processing clk.
  task automatic model_tick(input bit wr, input int d);
    if (wr) m_pending = (d > SPAN) ? SPAN : d;
    if (!m_active) begin
      if (enable) model_start(1'b0);
    end else begin
      m_pos++;
      if (m_pos == FRAME_TICKS) begin
        if (enable) model_start(1'b1);
        else        m_active = 1'b0;
      end
    end
  endtask

  // Driver: one divider period of TICK_CLKS clks. An optional position
  // write is presented on the clk where the DUT acts on this tick.
  task automatic tick_once(input bit wr, input logic [POS_W-1:0] d);
    tick_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick_in = 1'b0;
    if (wr) begin
      pos_valid = 1'b1;
      pos_data  = d;
    end
    model_tick(wr, int'(d));
    @(posedge clk); #1;
    pos_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick_once(1'b0, '0);
  endtask

  // Monitor: pop an expectation at each frame start, then check the
  // applied width, the frame period and the pulse length.
  int  clk_ctr  = 0;
  int  last_fs  = 0;
  int  high_clks = 0;
  int  cur_exp  = 0;
  bit  in_pulse = 1'b0;

  always @(negedge clk) begin
    logic [CNT_W:0] e;
    if (rst) begin
      in_pulse = 1'b0;
    end else begin
      clk_ctr++;
      if (frame_start) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_width", int'(cur_width), int'(e[CNT_W-1:0]));
          if (e[CNT_W]) check("frame_period_clks", clk_ctr - last_fs, FRAME_TICKS * TICK_CLKS);
          last_fs   = clk_ctr;
          cur_exp   = int'(e[CNT_W-1:0]);
          in_pulse  = 1'b1;
          high_clks = 0;
        end
      end
      if (in_pulse) begin
        if (pwm_out) high_clks++;
        else begin
          check("pulse_clks", high_clks, cur_exp * TICK_CLKS);
          in_pulse = 1'b0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [POS_W-1:0] r;
    rst       = 1'b1;
    tick_in   = 1'b0;
    enable    = 1'b0;
    pos_data  = '0;
    pos_valid = 1'b0;
    m_frames  = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_pos_ready", int'(pos_ready), 0);
    check("rst_cur_width", int'(cur_width), 150);
    check("rst_state", int'(state_dbg), int'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("pos_ready_after_rst", int'(pos_ready), 1);

    // Frame 1: neutral width, no writes
    enable = 1'b1;
    run_ticks(FRAME_TICKS);
    // Frame 2: write position 0 mid-pulse; takes effect in frame 3
    run_ticks(21);
    tick_once(1'b1, 8'd0);
    run_ticks(FRAME_TICKS - 22);
    // Frame 3: write an out-of-range position
    run_ticks(300);
    tick_once(1'b1, 8'd200);
    run_ticks(FRAME_TICKS - 301);
    // Frame 4: write on the load clk, then sparse random writes
    tick_once(1'b1, 8'd100);
    for (int i = 1; i < FRAME_TICKS; i++)
      tick_once(($urandom_range(0, 99) == 0), POS_W'($urandom_range(0, 255)));
    // Frame 5: random write on the load clk
    r = POS_W'($urandom_range(0, 255));
    tick_once(1'b1, r);
    run_ticks(FRAME_TICKS - 1);
    // Frame 6: drop enable at tick 50 of the pulse
    run_ticks(50);
    enable = 1'b0;
    run_ticks(FRAME_TICKS - 50);
    run_ticks(10);
    check("idle_pwm_out", int'(pwm_out), 0);
    check("idle_state", int'(state_dbg), int'(ST_IDLE));
    check("idle_frame_count", m_frames, 6);
    // Write while idle, then re-enable: frame 7 starts on the next tick
    tick_once(1'b1, POS_W'($urandom_range(0, 255)));
    enable = 1'b1;
    run_ticks(80);
    check("pre_rst_pwm_high", int'(pwm_out), 1);
    // Asynchronous reset during the high phase
    rst = 1'b1;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_pos_ready", int'(pos_ready), 0);
    check("async_rst_cur_width", int'(cur_width), 150);
    check("async_rst_state", int'(state_dbg), int'(ST_IDLE));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cur_width", int'(cur_width), 150);
    check("post_rst_state", int'(state_dbg), int'(ST_IDLE));
    check("post_rst_pos_ready", int'(pos_ready), 1);
    // Frame 8: restarts from neutral
    run_ticks(400);
    check("queue_drained", exp_q.size(), 0);
    check("frames_seen", frames_seen, m_frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
